// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg.sv
// Shared definitions for the multi-channel programmable clock divider.
package gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } clkdiv_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 2;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_ch.sv
// One divided-clock channel: half-period of (R+1) cycles, ratio updates only at half-period boundaries.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | Z held low, counter cleared; LD writes the ratio directly
//   ST_RUN  | counting, Z toggles at every terminal count
//   ST_STOP | enable dropped while Z high; finish the high phase, then IDLE
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_ch
    import gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_ld,
    output logic             o_ack,
    output logic             o_tc,
    output logic             o_z
);

    clkdiv_state_e    r_state, w_state;
    logic [WIDTH-1:0] r_cnt,   w_cnt;
    logic [WIDTH-1:0] r_ratio, w_ratio;
    logic [WIDTH-1:0] r_pend,  w_pend;
    logic             r_pv,    w_pv;
    logic             r_z,     w_z;
    logic             r_tc,    w_tc;
    logic             r_ack,   w_ack;
    logic             w_term;

    assign w_term = (r_cnt == r_ratio);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ratio = r_ratio;
        w_pend  = r_pend;
        w_pv    = r_pv;
        w_z     = r_z;
        w_tc    = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt = '0;
                w_z   = 1'b0;
                if (i_ld) begin
                    w_ratio = i_div;
                    w_pv    = 1'b0;
                    w_ack   = 1'b1;
                end
                if (i_en) w_state = ST_RUN;
            end
            ST_RUN, ST_STOP: begin
                // A low phase can be abandoned at once; a high phase is always completed.
                if (r_state == ST_RUN && !i_en && !r_z) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                end else begin
                    if (w_term) begin
                        w_cnt = '0;
                        w_z   = ~r_z;
                        w_tc  = 1'b1;
                        if (r_pv) begin
                            w_ratio = r_pend;
                            w_pv    = 1'b0;
                            w_ack   = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + WIDTH'(1);
                    end
                    if (i_en)        w_state = ST_RUN;
                    else if (w_term) w_state = ST_IDLE;
                    else             w_state = ST_STOP;
                end
                // Loads while running always queue behind any ratio being applied now.
                if (i_ld) begin
                    w_pend = i_div;
                    w_pv   = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
                w_z     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ratio <= '0;
            r_pend  <= '0;
            r_pv    <= 1'b0;
            r_z     <= 1'b0;
            r_tc    <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ratio <= w_ratio;
            r_pend  <= w_pend;
            r_pv    <= w_pv;
            r_z     <= w_z;
            r_tc    <= w_tc;
            r_ack   <= w_ack;
        end
    end

    assign o_ack = r_ack;
    assign o_tc  = r_tc;
    assign o_z   = r_z;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_n.sv
// NCH independent programmable clock dividers sharing one clock and synchronous reset.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_n
    import gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*WIDTH-1:0] DIV,
    input  logic [NCH-1:0]       LD,
    output logic [NCH-1:0]       ACK,
    output logic [NCH-1:0]       TC,
    output logic [NCH-1:0]       Z
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        gf180mcu_fd_sc_mcu7t5v0__clkdiv_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst_n (RN),
            .i_en    (EN[k]),
            .i_div   (DIV[k*WIDTH +: WIDTH]),
            .i_ld    (LD[k]),
            .o_ack   (ACK[k]),
            .o_tc    (TC[k]),
            .o_z     (Z[k])
        );
    end

`ifndef FUNCTIONAL
    specify
        (CLK *> Z)   = 1;
        (CLK *> TC)  = 1;
        (CLK *> ACK) = 1;
    endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n.sv
// Scoreboard bench: a cycle-level behavioural model predicts ACK/TC/Z, a monitor compares each cycle.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n;

    localparam int WIDTH = 4;
    localparam int NCH   = 2;
    localparam int NRAND = 3000;

    logic                 CLK = 1'b0;
    logic                 RN;
    logic [NCH-1:0]       EN;
    logic [NCH*WIDTH-1:0] DIV;
    logic [NCH-1:0]       LD;
    logic [NCH-1:0]       ACK;
    logic [NCH-1:0]       TC;
    logic [NCH-1:0]       Z;

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_n #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .CLK (CLK),
        .RN  (RN),
        .EN  (EN),
        .DIV (DIV),
        .LD  (LD),
        .ACK (ACK),
        .TC  (TC),
        .Z   (Z)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NCH-1:0] ack;
        logic [NCH-1:0] tc;
        logic [NCH-1:0] z;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: mode 0=idle, 1=running, 2=finishing a high phase; m_left = cycles left in this half-period.
    int m_mode[NCH];
    int m_left[NCH];
    int m_ratio[NCH];
    int m_pend[NCH];
    bit m_pv[NCH];
    bit m_z[NCH];

    task automatic check_vec(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic [NCH-1:0] en, input logic [NCH-1:0] ld,
                         input logic [NCH*WIDTH-1:0] div);
        exp_t e;
        int   d;
        bit   last;
        @(negedge CLK);
        RN  = rn;
        EN  = en;
        LD  = ld;
        DIV = div;
        e   = '0;
        for (int c = 0; c < NCH; c++) begin
            d = int'(div[c*WIDTH +: WIDTH]);
            if (!rn) begin
                m_mode[c] = 0; m_left[c] = 0; m_ratio[c] = 0;
                m_pend[c] = 0; m_pv[c] = 0;   m_z[c] = 0;
            end else if (m_mode[c] == 0) begin
                if (ld[c]) begin
                    m_ratio[c] = d;
                    m_pv[c]    = 0;
                    e.ack[c]   = 1'b1;
                end
                if (en[c]) begin
                    m_mode[c] = 1;
                    m_left[c] = m_ratio[c] + 1;
                end
                m_z[c] = 0;
            end else begin
                if (m_mode[c] == 1 && !en[c] && !m_z[c]) begin
                    m_mode[c] = 0;
                    m_left[c] = 0;
                end else begin
                    last = (m_left[c] == 1);
                    if (last) begin
                        m_z[c]  = !m_z[c];
                        e.tc[c] = 1'b1;
                        if (m_pv[c]) begin
                            m_ratio[c] = m_pend[c];
                            m_pv[c]    = 0;
                            e.ack[c]   = 1'b1;
                        end
                        m_left[c] = m_ratio[c] + 1;
                    end else begin
                        m_left[c]--;
                    end
                    m_mode[c] = en[c] ? 1 : (last ? 0 : 2);
                end
                if (ld[c]) begin
                    m_pend[c] = d;
                    m_pv[c]   = 1;
                end
            end
            e.z[c] = m_z[c];
        end
        exp_q.push_back(e);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec("Z",   Z,   e.z);
            check_vec("TC",  TC,  e.tc);
            check_vec("ACK", ACK, e.ack);
        end
    end

    initial begin
        logic [NCH-1:0]       en_r;
        logic [NCH-1:0]       ld_r;
        logic [NCH*WIDTH-1:0] div_r;
        logic                 rn_r;

        RN = 1'b0; EN = '0; LD = '0; DIV = '0;
        drive(1'b0, 2'b00, 2'b00, 8'h00);
        drive(1'b0, 2'b00, 2'b00, 8'h00);

        // Ratio 3 loaded in idle, then run: period 8.
        drive(1'b1, 2'b00, 2'b01, 8'h03);
        repeat (20) drive(1'b1, 2'b01, 2'b00, 8'h00);
        // Load ratio 1 mid-half-period.
        drive(1'b1, 2'b01, 2'b01, 8'h01);
        repeat (16) drive(1'b1, 2'b01, 2'b00, 8'h00);
        // Two loads before a terminal: latest wins.
        drive(1'b1, 2'b01, 2'b01, 8'h05);
        drive(1'b1, 2'b01, 2'b01, 8'h07);
        repeat (40) drive(1'b1, 2'b01, 2'b00, 8'h00);

        // Ratio 2: drop enable right after Z rises.
        drive(1'b0, 2'b00, 2'b00, 8'h00);
        drive(1'b1, 2'b01, 2'b01, 8'h02);
        repeat (3) drive(1'b1, 2'b01, 2'b00, 8'h00);
        repeat (8) drive(1'b1, 2'b00, 2'b00, 8'h00);
        // Stop then resume one cycle later.
        drive(1'b1, 2'b01, 2'b00, 8'h00);
        repeat (3) drive(1'b1, 2'b01, 2'b00, 8'h00);
        drive(1'b1, 2'b00, 2'b00, 8'h00);
        repeat (12) drive(1'b1, 2'b01, 2'b00, 8'h00);

        // Two channels, ratios 0 and 4; channel 1 loads, then reset mid-run.
        drive(1'b1, 2'b00, 2'b11, 8'h40);
        repeat (10) drive(1'b1, 2'b11, 2'b00, 8'h00);
        drive(1'b1, 2'b11, 2'b10, 8'h20);
        repeat (7) drive(1'b1, 2'b11, 2'b00, 8'h00);
        drive(1'b0, 2'b11, 2'b00, 8'h00);
        drive(1'b1, 2'b11, 2'b11, 8'h21);
        repeat (10) drive(1'b1, 2'b11, 2'b00, 8'h00);

        en_r = 2'b11;
        for (int n = 0; n < NRAND; n++) begin
            rn_r = ($urandom_range(0, 249) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 19) == 0) en_r[c] = ~en_r[c];
                ld_r[c] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 1) == 0)
                    div_r[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
                else
                    div_r[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
            end
            drive(rn_r, en_r, ld_r, div_r);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__clkdiv_n.md
GF180MCU_FD_SC_MCU7T5V0__CLKDIV_N -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_n

Interface
REQ-001 Parameter WIDTH, default 4: width of each channel's divide-ratio field and counter.
REQ-002 Parameter NCH, default 2: number of independent divided-clock channels.
REQ-003 The ports SHALL be, one per line:
- CLK  input  1  single clock; all logic on its rising edge.
- RN  input  1  reset, synchronous, active-low.
- EN  input  NCH  per-channel run enable.
- DIV  input  NCH*WIDTH  per-channel ratio value; channel k uses bits [k*WIDTH +: WIDTH].
- LD  input  NCH  per-channel single-cycle load strobe for DIV.
- ACK  output  NCH  one-cycle pulse when the loaded ratio takes effect.
- TC  output  NCH  one-cycle pulse at every half-period boundary.
- Z  output  NCH  divided clock, registered, glitch-free.

Function
REQ-004 Each channel SHALL hold: state (IDLE, RUN, STOP), counter cnt[WIDTH], active ratio R[WIDTH], pending ratio P[WIDTH] and pending flag PV.
REQ-005 Half-period SHALL be R+1 CLK cycles, so Z period = 2*(R+1) cycles. R=0 gives CLK/2.
REQ-006 RUN behaviour, when cnt==R (terminal):
- cnt<=0, Z<=~Z, TC<=1.
- If PV is set: R<=P, PV<=0 and ACK<=1 in the same cycle.
REQ-007 RUN behaviour, when cnt!=R: cnt<=cnt+1 and TC<=0.
REQ-008 LD in RUN or STOP SHALL set P<=DIV slice and PV<=1. A second LD before application overwrites P (latest wins).
REQ-009 LD coincident with a terminal cycle SHALL leave the current ratio application (if any) as in REQ-006. The new value becomes pending and is applied at the next terminal.
REQ-010 LD in IDLE SHALL load R<=DIV next cycle, pulse ACK that cycle and leave PV=0.
REQ-011 IDLE with EN=1 SHALL enter RUN next cycle with cnt=0 and Z=0. The first Z rise occurs R+1 cycles after RUN entry.
REQ-012 RUN with EN=0 and Z=0 SHALL go to IDLE next cycle with cnt<=0. Z stays 0.
REQ-013 RUN with EN=0 and Z=1 SHALL go to STOP and keep counting. At terminal: Z<=0, cnt<=0, TC<=1, then IDLE. No truncated high phase.
REQ-014 STOP with EN=1 SHALL return to RUN without altering cnt or Z.
REQ-015 IDLE SHALL hold Z=0, TC=0 and cnt=0.
REQ-016 Z, TC and ACK SHALL be flop outputs, with no combinational path from any input.
REQ-017 Channels SHALL be fully independent; no cross-channel interaction.
REQ-018 Counter arithmetic is WIDTH-bit unsigned. cnt never exceeds R, because R changes only at terminal with cnt<=0.

Reset
REQ-019 With RN=0 at a CLK edge, every channel SHALL take: state=IDLE, cnt=0, R=0, P=0, PV=0, Z=0, TC=0, ACK=0.
REQ-020 Reset asserted mid-period SHALL abort immediately: Z goes low at that edge, and pending loads are discarded.
REQ-021 EN and LD sampled in the cycle RN returns high SHALL be acted on normally.

Structure
REQ-022 A shared package gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, STOP=2'b10) and default WIDTH/NCH constants.
REQ-023 One sub-module gf180mcu_fd_sc_mcu7t5v0__clkdiv_ch (single channel, WIDTH parameter) SHALL be instantiated NCH times via generate.
REQ-024 A specify block SHALL provide unit-delay CLK=>Z, CLK=>TC and CLK=>ACK arcs outside `FUNCTIONAL, consistent with library cells.

Verification
REQ-025 Reset, then LD=1 with DIV=3 in IDLE, then EN=1: ACK pulses once, and Z has period 8 with 4 high and 4 low; first rise 4 cycles after RUN entry.
REQ-026 Running at R=3, LD DIV=1 mid-half-period: ACK and the change occur at the next terminal only. Following half-periods are 2 cycles, with no short pulse on Z.
REQ-027 Running at R=2, drop EN while Z=1 with cnt=0: Z stays high 3 cycles total, falls with TC, and the channel is IDLE.
REQ-028 STOP entered at R=2, re-assert EN one cycle later: Z waveform is identical to uninterrupted run.
REQ-029 Two LDs (DIV=5 then DIV=7) before a terminal: only ratio 7 is applied, with exactly one ACK.
REQ-030 NCH=2, channel 0 R=0, channel 1 R=4; RN pulsed low mid-run: both Z=0 next edge, all state cleared, and channel 0 is unaffected by channel 1 loads.
